// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order prediction queue that checks fetch-time predictions at execute and drives predictor updates.
// Optional BRANCH_RESOLVER_STATS_EN adds saturating BR_CNT / MISP_CNT counters.
module branch_resolver #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_V1,
  input  logic        F_V2,
  input  logic [31:0] F_PC1,
  input  logic [31:0] F_PC2,
  input  logic        F_P1,
  input  logic        F_P2,
  input  logic [31:0] F_TGT1,
  input  logic [31:0] F_TGT2,
  output logic        STALL,
  input  logic        X_V1,
  input  logic        X_V2,
  input  logic        X_T1,
  input  logic        X_T2,
  input  logic [31:0] X_TGT1,
  input  logic [31:0] X_TGT2,
  output logic        US1,
  output logic        US2,
  output logic        T1,
  output logic        T2,
  output logic        WE1,
  output logic        WE2,
  output logic [31:0] WA1,
  output logic [31:0] WA2,
  output logic [31:0] WD1,
  output logic [31:0] WD2,
  output logic        MISP,
  output logic [31:0] REDIRECT_PC
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] BR_CNT,
  output logic [31:0] MISP_CNT
`endif
);

  localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 2);

  logic [31:0]   q_pc  [DEPTH];
  logic          q_p   [DEPTH];
  logic [31:0]   q_tgt [DEPTH];

  logic [AW-1:0] head, tail, head_n1, tail_n1;
  logic [AW:0]   count, count_next;

  logic          push1, push2, rs1, rs2, upd2;
  logic          miss1, miss2, flush;
  logic [1:0]    pushes, pops;
  logic [31:0]   pc1, pc2, tgt1, tgt2, redirect;
  logic          p1, p2;

  assign STALL   = count > STALL_LVL;
  assign head_n1 = head + 1'b1;
  assign tail_n1 = tail + 1'b1;

  always_comb begin
    push1 = F_V1 & ~STALL;
    push2 = push1 & F_V2;
    // Resolves only see entries present at the start of the cycle.
    rs1   = X_V1 & (count != '0);
    rs2   = X_V1 & X_V2 & (count[AW:1] != '0);

    pc1  = q_pc[head];
    p1   = q_p[head];
    tgt1 = q_tgt[head];
    pc2  = q_pc[head_n1];
    p2   = q_p[head_n1];
    tgt2 = q_tgt[head_n1];

    miss1 = rs1 & ((p1 != X_T1) | (X_T1 & (tgt1 != X_TGT1)));
    // A lane-1 mispredict makes lane 2 wrong-path: no update, no pop.
    upd2  = rs2 & ~miss1;
    miss2 = upd2 & ((p2 != X_T2) | (X_T2 & (tgt2 != X_TGT2)));
    flush = miss1 | miss2;

    if (miss1)
      redirect = X_T1 ? X_TGT1 : pc1 + 32'd4;
    else
      redirect = X_T2 ? X_TGT2 : pc2 + 32'd4;

    pushes     = 2'(push1) + 2'(push2);
    pops       = 2'(rs1) + 2'(upd2);
    count_next = count + (AW+1)'(pushes) - (AW+1)'(pops);
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push1) begin
      q_pc[tail]  <= F_PC1;
      q_p[tail]   <= F_P1;
      q_tgt[tail] <= F_TGT1;
      if (push2) begin
        q_pc[tail_n1]  <= F_PC2;
        q_p[tail_n1]   <= F_P2;
        q_tgt[tail_n1] <= F_TGT2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      US1         <= 1'b0;
      US2         <= 1'b0;
      T1          <= 1'b0;
      T2          <= 1'b0;
      WE1         <= 1'b0;
      WE2         <= 1'b0;
      WA1         <= '0;
      WA2         <= '0;
      WD1         <= '0;
      WD2         <= '0;
      MISP        <= 1'b0;
      REDIRECT_PC <= '0;
    end else begin
      US1         <= rs1;
      US2         <= upd2;
      T1          <= rs1 & X_T1;
      T2          <= upd2 & X_T2;
      WE1         <= rs1 & X_T1;
      WE2         <= upd2 & X_T2;
      WA1         <= rs1 ? pc1 : '0;
      WA2         <= upd2 ? pc2 : '0;
      WD1         <= rs1 ? X_TGT1 : '0;
      WD2         <= upd2 ? X_TGT2 : '0;
      MISP        <= flush;
      REDIRECT_PC <= flush ? redirect : '0;
      // Flush beats any same-cycle push: tail stays, head catches up.
      if (flush) begin
        count <= '0;
        head  <= tail;
      end else begin
        count <= count_next;
        head  <= head + AW'(pops);
        tail  <= tail + AW'(pushes);
      end
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [32:0] br_sum, misp_sum;

  always_comb begin
    br_sum   = {1'b0, BR_CNT} + 33'(pops);
    misp_sum = {1'b0, MISP_CNT} + 33'(flush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      BR_CNT   <= '0;
      MISP_CNT <= '0;
    end else begin
      BR_CNT   <= br_sum[32] ? 32'hFFFF_FFFF : br_sum[31:0];
      MISP_CNT <= misp_sum[32] ? 32'hFFFF_FFFF : misp_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver.
module tb_branch_resolver;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk, reset;
  logic        F_V1, F_V2, F_P1, F_P2;
  logic [31:0] F_PC1, F_PC2, F_TGT1, F_TGT2;
  logic        STALL;
  logic        X_V1, X_V2, X_T1, X_T2;
  logic [31:0] X_TGT1, X_TGT2;
  logic        US1, US2, T1, T2, WE1, WE2, MISP;
  logic [31:0] WA1, WA2, WD1, WD2, REDIRECT_PC;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] BR_CNT, MISP_CNT;
`endif

  branch_resolver #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .F_V1(F_V1), .F_V2(F_V2), .F_PC1(F_PC1), .F_PC2(F_PC2),
    .F_P1(F_P1), .F_P2(F_P2), .F_TGT1(F_TGT1), .F_TGT2(F_TGT2),
    .STALL(STALL),
    .X_V1(X_V1), .X_V2(X_V2), .X_T1(X_T1), .X_T2(X_T2),
    .X_TGT1(X_TGT1), .X_TGT2(X_TGT2),
    .US1(US1), .US2(US2), .T1(T1), .T2(T2), .WE1(WE1), .WE2(WE2),
    .WA1(WA1), .WA2(WA2), .WD1(WD1), .WD2(WD2),
    .MISP(MISP), .REDIRECT_PC(REDIRECT_PC)
`ifdef BRANCH_RESOLVER_STATS_EN
    , .BR_CNT(BR_CNT), .MISP_CNT(MISP_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        us1, us2, t1, t2, we1, we2, misp;
    logic [31:0] wa1, wa2, wd1, wd2, rpc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc[$];
  logic        m_p[$];
  logic [31:0] m_tgt[$];
  logic [31:0] br_exp, misp_exp;
  int          checks, failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    F_V1 = 0; F_V2 = 0; F_P1 = 0; F_P2 = 0;
    F_PC1 = '0; F_PC2 = '0; F_TGT1 = '0; F_TGT2 = '0;
    X_V1 = 0; X_V2 = 0; X_T1 = 0; X_T2 = 0; X_TGT1 = '0; X_TGT2 = '0;
  endtask

  // Builds the expected update for the inputs now driven, advances the model, then checks after the edge.
  task automatic cycle();
    exp_t e;
    exp_t got;
    int   n;
    logic stall_e, r1, r2, mis1, u2, mis2;
    n = m_pc.size();
    stall_e = (n > DEPTH - 2);
    if (!reset) check("stall", STALL, stall_e);
    e = '{default: '0};
    if (reset) begin
      m_pc.delete(); m_p.delete(); m_tgt.delete();
      br_exp = 0; misp_exp = 0;
    end else begin
      r1   = X_V1 && n >= 1;
      r2   = X_V1 && X_V2 && n >= 2;
      mis1 = r1 && ((m_p[0] != X_T1) || (X_T1 && m_tgt[0] != X_TGT1));
      u2   = r2 && !mis1;
      mis2 = u2 && ((m_p[1] != X_T2) || (X_T2 && m_tgt[1] != X_TGT2));
      if (r1) begin
        e.us1 = 1; e.t1 = X_T1; e.we1 = X_T1; e.wa1 = m_pc[0]; e.wd1 = X_TGT1;
      end
      if (u2) begin
        e.us2 = 1; e.t2 = X_T2; e.we2 = X_T2; e.wa2 = m_pc[1]; e.wd2 = X_TGT2;
      end
      e.misp = mis1 || mis2;
      if (mis1)      e.rpc = X_T1 ? X_TGT1 : m_pc[0] + 32'd4;
      else if (mis2) e.rpc = X_T2 ? X_TGT2 : m_pc[1] + 32'd4;
      br_exp   = br_exp + 32'(r1) + 32'(u2);
      misp_exp = misp_exp + 32'(e.misp);
      if (e.misp) begin
        m_pc.delete(); m_p.delete(); m_tgt.delete();
      end else begin
        if (r1) begin void'(m_pc.pop_front()); void'(m_p.pop_front()); void'(m_tgt.pop_front()); end
        if (u2) begin void'(m_pc.pop_front()); void'(m_p.pop_front()); void'(m_tgt.pop_front()); end
        if (!stall_e && F_V1) begin
          m_pc.push_back(F_PC1); m_p.push_back(F_P1); m_tgt.push_back(F_TGT1);
          if (F_V2) begin
            m_pc.push_back(F_PC2); m_p.push_back(F_P2); m_tgt.push_back(F_TGT2);
          end
        end
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("us1", US1, got.us1);   check("us2", US2, got.us2);
    check("t1", T1, got.t1);      check("t2", T2, got.t2);
    check("we1", WE1, got.we1);   check("we2", WE2, got.we2);
    check("wa1", WA1, got.wa1);   check("wa2", WA2, got.wa2);
    check("wd1", WD1, got.wd1);   check("wd2", WD2, got.wd2);
    check("misp", MISP, got.misp); check("redirect_pc", REDIRECT_PC, got.rpc);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("br_cnt", BR_CNT, br_exp);
    check("misp_cnt", MISP_CNT, misp_exp);
`endif
  endtask

  task automatic push(input logic [31:0] pc1, input logic p1, input logic [31:0] t1,
                      input logic v2, input logic [31:0] pc2, input logic p2, input logic [31:0] t2);
    F_V1 = 1; F_PC1 = pc1; F_P1 = p1; F_TGT1 = t1;
    F_V2 = v2; F_PC2 = pc2; F_P2 = p2; F_TGT2 = t2;
  endtask

  // Drives resolve lanes with the model's own predictions so nothing mispredicts.
  task automatic resolve_ok(input logic two);
    if (m_pc.size() > 0) begin
      X_V1 = 1; X_T1 = m_p[0]; X_TGT1 = m_p[0] ? m_tgt[0] : 32'h0000_0AA0;
    end
    if (two && m_pc.size() > 1) begin
      X_V2 = 1; X_T2 = m_p[1]; X_TGT2 = m_p[1] ? m_tgt[1] : 32'h0000_0BB0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; br_exp = 0; misp_exp = 0;
    idle(); reset = 1; cycle();
    reset = 1; cycle();

    // Correct two-lane resolve.
    idle(); push(32'h100, 1, 32'h200, 1, 32'h104, 0, 32'h0); cycle();
    idle(); X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h200; X_V2 = 1; X_T2 = 0; X_TGT2 = 32'h108; cycle();
    idle(); X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h200; cycle();

    // Direction mispredict on lane 1.
    idle(); push(32'h300, 0, 32'h0, 0, 32'h0, 0, 32'h0); cycle();
    idle(); X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h400; cycle();
    idle(); cycle();

    // Target mispredict on lane 1 with a same-cycle push that must be dropped.
    idle(); push(32'h500, 1, 32'h500, 1, 32'h504, 1, 32'h800); cycle();
    idle(); X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h600; X_V2 = 1; X_T2 = 1; X_TGT2 = 32'h800;
    push(32'h700, 1, 32'h710, 0, 32'h0, 0, 32'h0); cycle();
    idle(); X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h710; cycle();

    // Fill to DEPTH-1, ignored push at STALL, then pop two.
    for (int i = 0; i < 3; i++) begin
      idle(); push(32'h2000 + 32'(i * 8), 1, 32'h3000 + 32'(i), 1, 32'h2004 + 32'(i * 8), 0, 32'h0); cycle();
    end
    idle(); push(32'h2100, 0, 32'h0, 0, 32'h0, 0, 32'h0); cycle();
    idle(); push(32'h2200, 1, 32'h2300, 1, 32'h2204, 1, 32'h2400); cycle();
    idle(); resolve_ok(1); cycle();
    idle(); cycle();

    // Mixed push/pop traffic to wrap the pointers.
    for (int i = 0; i < 20; i++) begin
      idle();
      push(32'h4000 + 32'(i * 8), 1'($urandom_range(0, 1)), $urandom,
           1'(i % 3 != 0), 32'h4004 + 32'(i * 8), 1'($urandom_range(0, 1)), $urandom);
      resolve_ok(1'(i % 2 == 0));
      cycle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle(); resolve_ok(1); cycle();
    end

    // Lane-2 not-taken mispredict with PC+4 wrapping to zero.
    idle(); push(32'hFFFF_FFF8, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 32'h10); cycle();
    idle(); X_V1 = 1; X_T1 = 0; X_V2 = 1; X_T2 = 0; cycle();

    // Reset with four entries queued, then a resolve must find nothing.
    idle(); push(32'h5000, 1, 32'h5100, 1, 32'h5004, 1, 32'h5200); cycle();
    idle(); push(32'h5008, 0, 32'h0, 1, 32'h500C, 0, 32'h0); cycle();
    idle(); reset = 1; X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h5100; cycle();
    idle(); X_V1 = 1; X_T1 = 1; X_TGT1 = 32'h5100; X_V2 = 1; cycle();
    idle(); cycle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution-side counterpart of the dual-lane branch predictor. It holds every prediction issued at fetch (two lanes per cycle) in an in-order queue.
- At execute it compares each prediction against the actual outcome and drives the predictor's update ports (WE/US/T/WA/WD for both lanes).
- On a misprediction it raises a one-cycle flush/redirect to the front end and empties the queue.

Parameters:
DEPTH, 8, prediction queue entries (power of two, >= 4)
AW, 3, queue pointer width, log2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
F_V1  input  1  fetch lane 1 carries a branch prediction to record
F_V2  input  1  fetch lane 2 carries a prediction; lane 2 is younger than lane 1
F_PC1, F_PC2  input  32  branch PC per lane
F_P1, F_P2  input  1  predicted direction per lane (predictor P1/P2)
F_TGT1, F_TGT2  input  32  predicted target per lane (predictor RD1/RD2)
STALL  output  1  queue cannot accept two entries this cycle
X_V1  input  1  oldest outstanding branch resolved this cycle
X_V2  input  1  second-oldest resolved this cycle; valid only with X_V1
X_T1, X_T2  input  1  actual taken per resolve lane
X_TGT1, X_TGT2  input  32  actual target per resolve lane
US1, US2  output  1  update direction history/PHT for lane
T1, T2  output  1  actual outcome to predictor
WE1, WE2  output  1  write target cache for lane
WA1, WA2  output  32  update address (branch PC)
WD1, WD2  output  32  actual target
MISP  output  1  mispredict pulse: flush younger work
REDIRECT_PC  output  32  correct fetch PC when MISP=1

Behaviour:
- Reset: count=0, head=tail=0. All registered outputs are 0, including US*, WE*, T*, WA*, WD*, MISP and REDIRECT_PC. Reset mid-operation discards all entries.
- Queue entry: {pc[31:0], p, tgt[31:0]}. Circular buffer; head/tail wrap modulo DEPTH.
- STALL is combinational: STALL = (count > DEPTH-2).
  - When STALL=1, F_V1 and F_V2 are ignored (no partial push).
  - F_V2 without F_V1 is ignored.
  - Push order: lane 1 at tail, lane 2 at tail+1.
- Resolve pops from head in order. X_V2 without X_V1 is ignored.
  - A resolve needs entries already present at the start of the cycle; there is no same-cycle bypass from push.
  - Resolving with count=0 is ignored. Resolving two with count=1 handles lane 1 only.
- Mispredict for lane k: (p != X_Tk) OR (X_Tk=1 AND tgt != X_TGTk).
- Update outputs are registered, with 1-cycle latency after the resolve edge:
  - USk = lane k resolved.
  - Tk = X_Tk, WAk = entry pc.
  - WEk = lane k resolved AND X_Tk=1.
  - WDk = X_TGTk.
  - All are 0 in cycles with no resolve.
- Lane 1 mispredicts: lane 1 updates normally. Lane 2 is treated as wrong-path: US2=WE2=0 and it is not popped.
- Lane 2 mispredicts: both lanes update.
- Any mispredict, on the next cycle:
  - MISP=1 for exactly one cycle.
  - REDIRECT_PC = X_TGTk if taken, else pc+4 (mod 2^32).
  - The queue is flushed: count=0, head=tail.
  - Same-cycle pushes are discarded; flush wins over push.
- No mispredict: count' = count + pushes - pops. Simultaneous push and pop are permitted at any fill level.

Optional Feature:
- Macro BRANCH_RESOLVER_STATS_EN adds outputs BR_CNT[31:0] and MISP_CNT[31:0].
  - BR_CNT increments by the number of lanes updated per cycle (0/1/2).
  - MISP_CNT increments by 1 per MISP.
  - Both are cleared by reset and saturate at 32'hFFFFFFFF.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, push PC1=0x100 (P=1, tgt 0x200) and PC2=0x104 (P=0). Next cycle resolve X_T1=1/0x200, X_T2=0 -> next cycle US1=US2=1, WE1=1, WE2=0, WA1=0x100, WD1=0x200, MISP=0, count=0.
- Push 0x300 with P=0, resolve X_T1=1, X_TGT1=0x400 -> US1=WE1=1, MISP=1 one cycle, REDIRECT_PC=0x400, queue empty.
- Two queued, lane 1 predicted taken 0x500 but X_TGT1=0x600 -> US2=0, MISP=1, REDIRECT_PC=0x600. A same-cycle push is discarded and count=0.
- Fill to DEPTH-1=7 -> STALL=1 and a push is ignored. Pop 2 with no push -> count=5, STALL=0. Continued push/pop across 20 entries verifies pointer wrap and in-order WA sequence.
- Lane 2 not-taken mispredict at PC 0xFFFFFFFC -> REDIRECT_PC=0x00000000 (wrap), US1=US2=1.
- Assert reset with 4 entries queued -> next cycle count=0 and all outputs 0. A resolve then yields no update. With BRANCH_RESOLVER_STATS_EN, both counters read 0.
